// File: rtl/osd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : osd_pkg
// Purpose  : Shared constants for the OSD command link: SPI opcodes, line
//            geometry, core-side command encoding and the transmit FSM state
//            type, plus a helper that maps a command to its opcode byte.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package osd_pkg;

  localparam logic [7:0] OSD_CMD_WRITE   = 8'h20;
  localparam logic [7:0] OSD_CMD_ENABLE  = 8'h41;
  localparam logic [7:0] OSD_CMD_DISABLE = 8'h40;

  localparam int OSD_LINES      = 8;
  localparam int OSD_LINE_BYTES = 256;
  localparam int OSD_LINE_W     = $clog2(OSD_LINES);

  // Core-side cmd encoding
  localparam logic [1:0] CMD_DISABLE = 2'b00;
  localparam logic [1:0] CMD_ENABLE  = 2'b01;
  localparam logic [1:0] CMD_WRITE   = 2'b10;
  localparam logic [1:0] CMD_RSVD    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_TAIL  = 2'd2,
    ST_GAP   = 2'd3
  } osd_state_e;

  // First byte on the wire for a command; the write opcode carries the line.
  function automatic logic [7:0] osd_opcode(input logic [1:0] cmd,
                                            input logic [OSD_LINE_W-1:0] line);
    logic [7:0] op;
    case (cmd)
      CMD_DISABLE: op = OSD_CMD_DISABLE;
      CMD_ENABLE:  op = OSD_CMD_ENABLE;
      CMD_WRITE:   op = OSD_CMD_WRITE | {{(8-OSD_LINE_W){1'b0}}, line};
      default:     op = 8'h00;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/osd_spi_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : osd_spi_tx_if
// Purpose  : Core-side command and byte-source bundle of the OSD SPI master.
// Ports    : req/cmd/line   - command request from the menu controller
//            busy/done      - transaction status back to the controller
//            rd_en/rd_addr  - byte fetch strobe and index into the line
//            rd_data        - fetched byte, valid the cycle after rd_en
//            modport master - controller / byte source side
//            modport slave  - osd_spi_tx side
// Revision : 1.0 - initial release
// ============================================================================
interface osd_spi_tx_if
  import osd_pkg::*;
;
  logic                  req;
  logic [1:0]            cmd;
  logic [OSD_LINE_W-1:0] line;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [7:0]            rd_addr;
  logic [7:0]            rd_data;

  modport master (output req, cmd, line, rd_data,
                  input  busy, done, rd_en, rd_addr);
  modport slave  (input  req, cmd, line, rd_data,
                  output busy, done, rd_en, rd_addr);
endinterface
`default_nettype wire

// File: rtl/spi_byte_shifter.sv
`default_nettype none
// ============================================================================
// Module   : spi_byte_shifter
// Purpose  : SCK half-period divider plus an 8-bit MSB-first shifter. A load
//            starts a byte with SCK low and DI at bit 7; each bit is CLK_DIV
//            cycles low then CLK_DIV cycles high. Reloading on byte_end gives
//            a continuous SCK stream across bytes.
// Ports    : clk_sys, reset_n - clock, synchronous active-low reset
//            load, data       - start a new byte (wins over normal shifting)
//            sck, di          - SPI clock and data
//            byte_start       - high during the first cycle of each byte
//            byte_end         - high in the last cycle of a byte's final
//                               high phase (the edge that drives SCK low)
// Revision : 1.0 - initial release
// ============================================================================
module spi_byte_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       sck,
  output logic       di,
  output logic       byte_start,
  output logic       byte_end
);

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;   // bits still to be sent after the one on DI
  logic       active;
  logic       tick;

  assign tick     = active && (div_cnt == 8'd0);
  assign byte_end = tick && sck && (bit_cnt == 3'd0);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      div_cnt    <= 8'd0;
      bit_cnt    <= 3'd0;
      shreg      <= 7'd0;
      active     <= 1'b0;
      sck        <= 1'b0;
      di         <= 1'b0;
      byte_start <= 1'b0;
    end else begin
      byte_start <= 1'b0;
      if (load) begin
        active     <= 1'b1;
        sck        <= 1'b0;
        di         <= data[7];
        shreg      <= data[6:0];
        div_cnt    <= DIV_RELOAD;
        bit_cnt    <= 3'd7;
        byte_start <= 1'b1;
      end else if (tick) begin
        div_cnt <= DIV_RELOAD;
        if (!sck) begin
          sck <= 1'b1;
        end else begin
          // Falling SCK: DI moves to the next bit on this same edge.
          sck <= 1'b0;
          if (bit_cnt == 3'd0) begin
            active <= 1'b0;
            di     <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt - 3'd1;
            di      <= shreg[6];
            shreg   <= {shreg[5:0], 1'b0};
          end
        end
      end else if (active) begin
        div_cnt <= div_cnt - 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/osd_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : osd_spi_tx
// Purpose  : SPI master for the OSD command link. Sends enable/disable
//            opcodes, or a write opcode followed by one 256-byte line fetched
//            from a core-side byte source, then holds SS3 high for a minimum
//            gap before reporting done.
// Ports    : clk_sys, reset_n - clock, synchronous active-low reset
//            bus              - osd_spi_tx_if.slave command / byte source
//            SPI_SCK          - SPI clock, idle low
//            SPI_SS3          - OSD chip select, active low
//            SPI_DI           - serial data, MSB first
// Revision : 1.0 - initial release
// ============================================================================
module osd_spi_tx
  import osd_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  osd_spi_tx_if.slave        bus,
  output logic               SPI_SCK,
  output logic               SPI_SS3,
  output logic               SPI_DI
);

  localparam logic [8:0] LAST_WRITE  = 9'(OSD_LINE_BYTES);
  localparam logic [7:0] TAIL_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_RELOAD  = 8'(CS_GAP - 1);

  osd_state_e state;
  osd_state_e state_nxt;

  logic       is_write;
  logic [8:0] byte_cnt;   // index of the byte on the wire; 0 is the opcode
  logic [7:0] wait_cnt;
  logic [7:0] rd_addr;
  logic [7:0] hold;
  logic       fetch;
  logic       fetch_d;
  logic       done_q;
  logic       accept;
  logic       last_byte;
  logic       load;
  logic [7:0] load_data;
  logic       byte_start;
  logic       byte_end;

  assign accept    = (state == ST_IDLE) && bus.req && (bus.cmd != CMD_RSVD);
  assign last_byte = (byte_cnt == (is_write ? LAST_WRITE : 9'd0));
  assign load      = accept || ((state == ST_SHIFT) && byte_end && !last_byte);
  assign load_data = accept ? osd_opcode(bus.cmd, bus.line) : hold;

  spi_byte_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .load       (load),
    .data       (load_data),
    .sck        (SPI_SCK),
    .di         (SPI_DI),
    .byte_start (byte_start),
    .byte_end   (byte_end)
  );

  // State register
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)                   state_nxt = ST_SHIFT;
      ST_SHIFT: if (byte_end && last_byte)    state_nxt = ST_TAIL;
      ST_TAIL:  if (wait_cnt == 8'd0)         state_nxt = ST_GAP;
      ST_GAP:   if (wait_cnt == 8'd0)         state_nxt = ST_IDLE;
      default:                                state_nxt = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    // One fetch per byte start, for the opcode and data bytes 0..254: each
    // fetch supplies the byte that follows the one now going out.
    fetch       = byte_start && is_write && (byte_cnt != LAST_WRITE);
    bus.rd_en   = fetch;
    bus.rd_addr = rd_addr;
    bus.busy    = (state != ST_IDLE);
    bus.done    = done_q;
    SPI_SS3     = (state == ST_IDLE) || (state == ST_GAP);
  end

  // Byte counter, prefetch path and tail/gap timer
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      is_write <= 1'b0;
      byte_cnt <= 9'd0;
      wait_cnt <= 8'd0;
      rd_addr  <= 8'd0;
      hold     <= 8'd0;
      fetch_d  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q  <= (state == ST_GAP) && (wait_cnt == 8'd0);
      fetch_d <= fetch;
      if (fetch_d) begin
        hold <= bus.rd_data;
      end
      if (accept) begin
        is_write <= (bus.cmd == CMD_WRITE);
        byte_cnt <= 9'd0;
        rd_addr  <= 8'd0;
      end else if (fetch) begin
        rd_addr <= rd_addr + 8'd1;  // wraps to 0 after 255 and stays there
      end
      if ((state == ST_SHIFT) && byte_end && !last_byte) begin
        byte_cnt <= byte_cnt + 9'd1;
      end
      case (state)
        ST_SHIFT: if (byte_end && last_byte) wait_cnt <= TAIL_RELOAD;
        ST_TAIL:  wait_cnt <= (wait_cnt == 8'd0) ? GAP_RELOAD : wait_cnt - 8'd1;
        ST_GAP:   if (wait_cnt != 8'd0) wait_cnt <= wait_cnt - 8'd1;
        default:  ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/osd_spi_tx.md
Name: osd_spi_tx

Overview:
SPI master that drives the OSD command link (SPI_SCK / SPI_SS3 / SPI_DI) from inside the core. It lets a local menu controller enable or disable the overlay and upload 256-byte OSD lines without the external io controller. It sits between a core-side command/byte-source interface and the OSD block's SPI slave input, in the clk_sys domain.

Parameters:
CLK_DIV, 4, clk_sys cycles per SCK half-period; legal range 2..255.
CS_GAP, 8, minimum clk_sys cycles SPI_SS3 stays high after a transaction, before done/ready.

Ports:
clk_sys  in  1  system clock; all logic on its rising edge.
reset_n  in  1  synchronous, active-low reset.
req  in  1  command request; sampled only while busy=0.
cmd  in  2  00 = disable, 01 = enable, 10 = write line, 11 = reserved.
line  in  3  OSD line index for write (buffer address line*256).
busy  out  1  high from the cycle after an accepted req until done.
done  out  1  one-cycle pulse when a transaction completes, including its gap.
rd_en  out  1  one-cycle byte fetch strobe.
rd_addr  out  8  byte index 0..255 within the line being written.
rd_data  in  8  byte data; valid the cycle after rd_en.
SPI_SCK  out  1  SPI clock; idle low.
SPI_SS3  out  1  OSD chip select, active low; idle high.
SPI_DI  out  1  serial data, MSB first; changes only while SCK is low.

Behaviour:
- Reset (reset_n=0 at a clk_sys edge): SPI_SS3=1, SPI_SCK=0, SPI_DI=0, busy=0, done=0, rd_en=0, rd_addr=0, FSM=IDLE.
- Reset mid-transaction: SS3 rises on the same edge. The slave discards its partial state. Any bytes already written to the buffer stay written.
- Opcodes (shared constants): disable=0x40, enable=0x41, write=0x20|line.
- Accept: in IDLE with req=1 and cmd!=11, latch cmd and line. On the next edge: busy=1, SS3=0, DI=opcode bit7, FSM=SHIFT. A req with cmd=11 is ignored: no transaction, no done. A req while busy=1 is ignored.
- Bit timing:
  - Each bit has a low phase (SCK=0, DI stable) of CLK_DIV cycles, then a high phase (SCK=1) of CLK_DIV cycles.
  - DI for the next bit updates on the same edge that drives SCK low.
  - One byte takes 16*CLK_DIV cycles.
- Byte count: enable/disable send 1 byte. Write sends 1 opcode byte plus 256 data bytes with no inter-byte gap. The SCK pattern is continuous.
- Prefetch:
  - rd_en pulses with rd_addr=0 on the cycle the opcode's first bit starts.
  - rd_en pulses with rd_addr=k+1 on the cycle data byte k's first bit starts, for k<255.
  - rd_data is captured into a holding register the following cycle and loaded into the shift register at the next byte boundary.
  - Exactly 256 rd_en pulses per write. rd_addr wraps to 0 after 255 and holds there.
- End:
  - After the last high phase, SCK goes low and is held for CLK_DIV cycles, then SS3=1 (FSM=GAP).
  - SS3-low duration = 16*CLK_DIV*nbytes + CLK_DIV.
  - GAP lasts CS_GAP cycles, then done=1 for one cycle, busy=0 and FSM=IDLE on the same edge.
  - A new req may be accepted on the cycle done is high.
- FSM states: IDLE -> SHIFT -> TAIL -> GAP -> IDLE.
- Counters:
  - Phase divider: 8 bits, counts down from CLK_DIV-1.
  - Bit counter: 3 bits.
  - Byte counter: 9 bits (0..256); it decides the last byte, not a comparison against rd_addr.

Decomposition:
- Shared package osd_pkg: opcode constants (OSD_CMD_WRITE=8'h20, OSD_CMD_ENABLE=8'h41, OSD_CMD_DISABLE=8'h40), OSD_LINES=8, OSD_LINE_BYTES=256, and the cmd encoding.
- One sub-module, spi_byte_shifter: the divider plus an 8-bit MSB-first shifter with a load/byte_start/byte_end handshake.
- osd_spi_tx holds the FSM, byte counter, prefetch and chip select.

Test Plan:
- Reset hold: reset_n=0 for 3 cycles mid-shift -> SS3=1, SCK=0, DI=0, busy=0 on the edge after each low sample.
- Enable, CLK_DIV=2, CS_GAP=4: req cmd=01 -> DI sequence 0,1,0,0,0,0,0,1 sampled on the 8 SCK rises; SS3 low exactly 34 cycles; done 4 cycles after SS3 rises.
- Write line=5, CLK_DIV=2, source returns rd_data=rd_addr^8'hA5:
  - first byte shifted is 0x25; SS3 low 257*32+2 = 8226 cycles; exactly 256 rd_en pulses;
  - a slave model loads buffer[0x500..0x5FF] with the expected pattern.
- Busy/illegal: req during a write and req with cmd=11 while idle -> no extra transaction, no done, rd_en count unchanged.
- Back-to-back: req held high across done -> second transaction's SS3 falls on the edge after done; gap is never shorter than CS_GAP.
- Mid-write reset at data byte 100 -> SS3 rises immediately; a following enable command is decoded correctly by the slave model.
